bp_cache_req_arbiter: RTL
=========================

// Module: bp_cache_req_arbiter
//
// PURPOSE
//  Shares one cache-engine request port (LCE/UCE side) among num_req_p cache
//  requesters, e.g. I$ miss path and a second I$/D$ client. Round-robin grant,
//  one outstanding miss at a time. Owner holds the engine from request
//  acceptance until cache_req_complete_i. Metadata, critical and complete are
//  steered to/from the owner only. Sits between bp_fe_icache/bp_be_dcache
//  request ports and the cache engine.
//
// PARAMETERS
//  num_req_p         2   number of requesters (>=2)
//  req_width_p       -   width of one cache_req packet (icache_req_width_lp)
//  metadata_width_p  -   width of one cache_req_metadata packet
//  lg_num_req_lp     `BSG_SAFE_CLOG2(num_req_p), derived, not overridable
//
// PORTS
//  clk_i                   in   1                        clock
//  reset_i                 in   1                        async reset, active-high
//  req_i                   in   num_req_p*req_width_p    per-requester request
//  req_v_i                 in   num_req_p                per-requester request valid
//  req_ready_o             out  num_req_p                request accepted (v&ready handshake)
//  metadata_i              in   num_req_p*metadata_width_p  per-requester metadata
//  metadata_v_i            in   num_req_p                metadata valid
//  complete_o              out  num_req_p                miss complete, owner only
//  critical_o              out  num_req_p                critical word returned, owner only
//  cache_req_o             out  req_width_p              to engine
//  cache_req_v_o           out  1                        to engine
//  cache_req_ready_i       in   1                        engine can accept request
//  cache_req_metadata_o    out  metadata_width_p         to engine
//  cache_req_metadata_v_o  out  1                        to engine
//  cache_req_complete_i    in   1                        engine finished miss
//  cache_req_critical_i    in   1                        engine critical-data strobe
//  owner_id_o              out  lg_num_req_lp            current/last owner
//  busy_o                  out  1                        state != e_ready
//
// BEHAVIOUR
//  - Reset (async, any cycle incl. mid-miss): state=e_ready, owner=0, rr
//    pointer=0 (requester 0 highest priority); all outputs 0 except those
//    driven combinationally from inputs in e_ready.
//  - States: e_ready -> e_md -> e_busy -> e_ready.
//  - e_ready: grant = round-robin over req_v_i starting at rr pointer.
//    cache_req_o=req_i[grant], cache_req_v_o=|req_v_i (0 latency pass-through).
//    req_ready_o[grant]=cache_req_ready_i; others 0. On handshake: latch
//    owner=grant, rr pointer=(grant+1) mod num_req_p, -> e_md.
//  - e_md: metadata_v_i[owner] -> cache_req_metadata_v_o, metadata_i[owner]
//    -> cache_req_metadata_o, same cycle; then -> e_busy. Non-owner
//    metadata_v_i ignored. req_ready_o all 0.
//  - e_busy: wait for cache_req_complete_i; complete_o[owner]=1 that cycle;
//    -> e_ready. New request is not accepted in the complete cycle (one-cycle
//    bubble, ready is state-qualified).
//  - critical_o[owner]=cache_req_critical_i in e_md/e_busy; 0 elsewhere.
//  - Complete in e_md: also legal (uncached/fast path); forward metadata if
//    valid, pulse complete_o[owner], -> e_ready.
//  - Stray complete/critical in e_ready: ignored, flagged by assertion.
//  - Requester dropping req_v_i before handshake is legal; grant recomputed.
//  - owner_id_o holds last owner after return to e_ready.
//
// STRUCTURE
//  - bp_cache_arb_state_e {e_ready, e_md, e_busy} in bp_common_pkg.
//  - Sub-module: bsg_arb_round_robin for grant (reset-to-0 pointer, advance
//    on handshake); FSM, owner register and steering muxes inline.
//
// TESTING
//  - Single req: req_v_i=01, ready=1 -> cache_req_v_o=1, req_ready_o=01,
//    next cycle md forwarded, complete 5 cycles later -> complete_o=01.
//  - Contention: req_v_i=11 held -> grants 0,1,0,1 across four misses.
//  - Backpressure: cache_req_ready_i=0 for 3 cycles -> req_ready_o=00,
//    state e_ready, cache_req_v_o=1 stable; handshake on 4th.
//  - Steering: owner=1, critical_i pulse -> critical_o=10; metadata_v_i=01
//    in e_md -> cache_req_metadata_v_o=0.
//  - Complete in e_md with metadata_v -> metadata_v_o and complete_o same
//    cycle, next cycle e_ready.
//  - Async reset asserted in e_busy -> busy_o=0, complete_o=00 immediately;
//    after release req_v_i=10 granted to requester 1 in first cycle.

Source files
------------

// File: rtl/bp_cache_req_arbiter_pkg.sv
// Shared types for the cache request arbiter.
// Holds the FSM state encoding and a width helper.
package bp_cache_req_arbiter_pkg;

  typedef enum logic [1:0] {
    e_ready = 2'd0,
    e_md    = 2'd1,
    e_busy  = 2'd2
  } bp_cache_arb_state_e;

  function automatic int safe_clog2(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/bp_cache_req_arbiter_if.sv
// Requester-side and engine-side signals of the arbiter.
// The slave modport is the arbiter's view; master is its environment.
interface bp_cache_req_arbiter_if
  import bp_cache_req_arbiter_pkg::*;
#(
  parameter int num_req_p        = 2,
  parameter int req_width_p      = 8,
  parameter int metadata_width_p = 8
);

  localparam int lg_num_req_lp = safe_clog2(num_req_p);

  logic [num_req_p*req_width_p-1:0]      req_i;
  logic [num_req_p-1:0]                  req_v_i;
  logic [num_req_p-1:0]                  req_ready_o;
  logic [num_req_p*metadata_width_p-1:0] metadata_i;
  logic [num_req_p-1:0]                  metadata_v_i;
  logic [num_req_p-1:0]                  complete_o;
  logic [num_req_p-1:0]                  critical_o;

  logic [req_width_p-1:0]                cache_req_o;
  logic                                  cache_req_v_o;
  logic                                  cache_req_ready_i;
  logic [metadata_width_p-1:0]           cache_req_metadata_o;
  logic                                  cache_req_metadata_v_o;
  logic                                  cache_req_complete_i;
  logic                                  cache_req_critical_i;

  logic [lg_num_req_lp-1:0]              owner_id_o;
  logic                                  busy_o;

  modport slave (
    input  req_i,
    input  req_v_i,
    output req_ready_o,
    input  metadata_i,
    input  metadata_v_i,
    output complete_o,
    output critical_o,
    output cache_req_o,
    output cache_req_v_o,
    input  cache_req_ready_i,
    output cache_req_metadata_o,
    output cache_req_metadata_v_o,
    input  cache_req_complete_i,
    input  cache_req_critical_i,
    output owner_id_o,
    output busy_o
  );

  modport master (
    output req_i,
    output req_v_i,
    input  req_ready_o,
    output metadata_i,
    output metadata_v_i,
    input  complete_o,
    input  critical_o,
    input  cache_req_o,
    input  cache_req_v_o,
    output cache_req_ready_i,
    input  cache_req_metadata_o,
    input  cache_req_metadata_v_o,
    output cache_req_complete_i,
    output cache_req_critical_i,
    input  owner_id_o,
    input  busy_o
  );

endinterface

// File: rtl/bp_cache_req_arbiter_rr.sv
// Round-robin grant over requester valids.
// Pointer marks the highest-priority requester; it moves past the winner on yumi.
module bp_cache_req_arbiter_rr
  import bp_cache_req_arbiter_pkg::*;
#(
  parameter int num_req_p = 2,
  parameter int lg_p      = safe_clog2(num_req_p)
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic [num_req_p-1:0] i_req_v,
  input  logic                 i_yumi,
  output logic [lg_p-1:0]      o_grant_id,
  output logic                 o_grant_v
);

  logic [lg_p-1:0]        r_ptr;
  logic [2*num_req_p-1:0] w_dbl;
  logic [num_req_p-1:0]   w_rot;
  logic [lg_p-1:0]        w_off;
  logic [lg_p:0]          w_sum;
  logic [lg_p:0]          w_wrap;
  logic [lg_p-1:0]        w_next;

  // Rotate so bit 0 is the pointer slot, then find the first set bit.
  assign w_dbl = {i_req_v, i_req_v} >> r_ptr;
  assign w_rot = w_dbl[num_req_p-1:0];

  always_comb begin
    w_off = '0;
    for (int k = num_req_p - 1; k >= 0; k--) begin
      if (w_rot[k]) w_off = lg_p'(k);
    end
  end

  assign w_sum  = {1'b0, r_ptr} + {1'b0, w_off};
  assign w_wrap = w_sum - (lg_p + 1)'(num_req_p);

  assign o_grant_v  = |w_rot;
  assign o_grant_id = (w_sum >= (lg_p + 1)'(num_req_p))
                    ? w_wrap[lg_p-1:0]
                    : w_sum[lg_p-1:0];

  assign w_next = (o_grant_id == lg_p'(num_req_p - 1))
                ? '0
                : o_grant_id + lg_p'(1);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_ptr <= '0;
    end else if (i_yumi) begin
      r_ptr <= w_next;
    end
  end

endmodule

// File: rtl/bp_cache_req_arbiter.sv
// Shares one cache-engine request port among several cache requesters.
// One miss in flight; the owner keeps the engine until the engine completes.
module bp_cache_req_arbiter
  import bp_cache_req_arbiter_pkg::*;
#(
  parameter int num_req_p        = 2,
  parameter int req_width_p      = 8,
  parameter int metadata_width_p = 8
) (
  input logic clk_i,
  input logic reset_i,
  bp_cache_req_arbiter_if.slave bus
);

  localparam int lg_num_req_lp = safe_clog2(num_req_p);

  bp_cache_arb_state_e      r_state;
  logic [lg_num_req_lp-1:0] r_owner;

  logic [lg_num_req_lp-1:0] w_grant_id;
  logic                     w_grant_v;
  logic                     w_ready_st;
  logic                     w_md_st;
  logic                     w_own_st;
  logic                     w_hs;
  logic                     w_done;
  logic [num_req_p-1:0]     w_req_ready;
  logic [num_req_p-1:0]     w_complete;
  logic [num_req_p-1:0]     w_critical;

  assign w_ready_st = (r_state == e_ready);
  assign w_md_st    = (r_state == e_md);
  assign w_own_st   = w_md_st | (r_state == e_busy);
  assign w_hs       = w_ready_st & w_grant_v & bus.cache_req_ready_i;
  assign w_done     = w_own_st & bus.cache_req_complete_i;

  bp_cache_req_arbiter_rr #(
    .num_req_p (num_req_p),
    .lg_p      (lg_num_req_lp)
  ) u_rr (
    .i_clk      (clk_i),
    .i_rst      (reset_i),
    .i_req_v    (bus.req_v_i),
    .i_yumi     (w_hs),
    .o_grant_id (w_grant_id),
    .o_grant_v  (w_grant_v)
  );

  // Request path is a zero-latency pass-through while idle.
  assign bus.cache_req_o =
    bus.req_i[w_grant_id*req_width_p +: req_width_p];
  assign bus.cache_req_v_o = w_ready_st & (|bus.req_v_i);

  always_comb begin
    w_req_ready = '0;
    if (w_ready_st && w_grant_v) begin
      w_req_ready[w_grant_id] = bus.cache_req_ready_i;
    end
  end

  assign bus.req_ready_o = w_req_ready;

  // Metadata comes only from the owner, and only in the cycle after acceptance.
  assign bus.cache_req_metadata_v_o =
    w_md_st & bus.metadata_v_i[r_owner];
  assign bus.cache_req_metadata_o = w_md_st
    ? bus.metadata_i[r_owner*metadata_width_p +: metadata_width_p]
    : '0;

  always_comb begin
    w_complete = '0;
    w_critical = '0;
    if (w_own_st) begin
      w_complete[r_owner] = bus.cache_req_complete_i;
      w_critical[r_owner] = bus.cache_req_critical_i;
    end
  end

  assign bus.complete_o = w_complete;
  assign bus.critical_o = w_critical;
  assign bus.owner_id_o = r_owner;
  assign bus.busy_o     = ~w_ready_st;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_state <= e_ready;
      r_owner <= '0;
    end else begin
      unique case (r_state)
        e_ready: begin
          if (w_hs) begin
            r_owner <= w_grant_id;
            r_state <= e_md;
          end
        end
        e_md: begin
          r_state <= w_done ? e_ready : e_busy;
        end
        e_busy: begin
          if (w_done) r_state <= e_ready;
        end
        default: r_state <= e_ready;
      endcase
    end
  end

  // The engine must not signal completion or critical data with no miss open.
  a_no_stray_strobe : assert property (
    @(posedge clk_i) disable iff (reset_i)
    w_ready_st |-> !(bus.cache_req_complete_i || bus.cache_req_critical_i)
  );

endmodule
